// File: rtl/miriscv_data_mem_if.sv
// LSU <-> data memory request/response bus.
// master: the LSU (initiator); slave: the data memory (responder).
interface miriscv_data_mem_if;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_rdata_o, data_err_o
  );
endinterface

// File: rtl/miriscv_data_mem.sv
// Single-port data memory responding to the LSU bus.
// Byte-lane writes, one-cycle registered full-word reads, and a one-cycle
// error pulse for requests that miss every mapped region.
// Optional MMIO window (LED register + free-running cycle counter) is built
// when MIRISCV_DMEM_MMIO_EN is defined; otherwise the window decodes as a miss.
module miriscv_data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] MMIO_ADDR   = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        arstn_i,
`ifdef MIRISCV_DMEM_MMIO_EN
  output logic [15:0] leds_o,
`endif
  miriscv_data_mem_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0] MEM_HI   = MEM_LO + (33'(DEPTH_WORDS) << 2);
  localparam logic [31:0] CNT_ADDR = MMIO_ADDR + 32'd4;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   word_off;
  logic [AW-1:0] idx;
  logic          in_mem;
  logic          hit_led;
  logic          hit_cnt;
  logic          mem_sel;
  logic          mem_wr;
  logic          rd_load;
  logic          rd_mem;
  logic [31:0]   rd_val;
  logic          err_nxt;
  logic          unused_off;

`ifdef MIRISCV_DMEM_MMIO_EN
  logic [31:0]   cycle_cnt;
  logic          led_wr;
`endif

  // Address decode: word index, 33-bit bounds check, MMIO window match
  always_comb begin
    word_off = bus.data_addr_i - BASE_ADDR;
    idx      = word_off[AW+1:2];
    in_mem   = ({1'b0, bus.data_addr_i} >= MEM_LO) &&
               ({1'b0, bus.data_addr_i} <  MEM_HI);
    hit_led  = (bus.data_addr_i[31:2] == MMIO_ADDR[31:2]);
    hit_cnt  = (bus.data_addr_i[31:2] == CNT_ADDR[31:2]);
    mem_sel  = in_mem && !hit_led && !hit_cnt;
  end

  assign unused_off = ^{word_off[31:AW+2], word_off[1:0]};

  // Request decode; everything is gated by data_req_i so idle X inputs are inert
  always_comb begin
    mem_wr  = 1'b0;
    rd_load = 1'b0;
    rd_mem  = 1'b0;
    rd_val  = 32'h0;
    err_nxt = 1'b0;
`ifdef MIRISCV_DMEM_MMIO_EN
    led_wr  = 1'b0;
`endif
    if (bus.data_req_i) begin
      if (mem_sel) begin
        mem_wr  = bus.data_we_i;
        rd_load = !bus.data_we_i;
        rd_mem  = !bus.data_we_i;
      end
`ifdef MIRISCV_DMEM_MMIO_EN
      else if (hit_led) begin
        led_wr  = bus.data_we_i;
        rd_load = !bus.data_we_i;
        rd_val  = {16'h0, leds_o};
      end else if (hit_cnt) begin
        rd_load = !bus.data_we_i;
        rd_val  = cycle_cnt;
      end
`endif
      else begin
        err_nxt = 1'b1;
        rd_load = !bus.data_we_i;
      end
    end
  end

  // Array write, byte-lane masked; blocked while reset is asserted
  always_ff @(posedge clk_i) begin
    if (mem_wr && arstn_i) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.data_be_i[n]) begin
          mem[idx][8*n +: 8] <= bus.data_wdata_i[8*n +: 8];
        end
      end
    end
  end

  // Registered read data and error pulse
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      bus.data_rdata_o <= 32'h0;
      bus.data_err_o   <= 1'b0;
    end else begin
      bus.data_err_o <= err_nxt;
      if (rd_load) begin
        bus.data_rdata_o <= rd_mem ? mem[idx] : rd_val;
      end
    end
  end

`ifdef MIRISCV_DMEM_MMIO_EN
  // LED register: lanes 0 and 1 only
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      leds_o <= 16'h0;
    end else if (led_wr) begin
      if (bus.data_be_i[0]) leds_o[7:0]  <= bus.data_wdata_i[7:0];
      if (bus.data_be_i[1]) leds_o[15:8] <= bus.data_wdata_i[15:8];
    end
  end

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cycle_cnt <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_miriscv_data_mem.sv
// Directed bench for miriscv_data_mem with a word-level reference model.
// Build with MIRISCV_DMEM_MMIO_EN defined to exercise the MMIO window.
module tb_miriscv_data_mem;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam logic [31:0] MMIO  = 32'h8000_0000;
  localparam logic [31:0] LAST  = BASE + 4 * DEPTH - 4;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic rel_pending = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err   = 1'b0;
  logic [31:0] mem_m [int];
`ifdef MIRISCV_DMEM_MMIO_EN
  logic [15:0] leds;
  logic [15:0] exp_leds = 16'h0;
  logic [31:0] cnt_m    = 32'h0;
`endif

  miriscv_data_mem_if bus ();

  miriscv_data_mem #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .MMIO_ADDR   (MMIO)
  ) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
`ifdef MIRISCV_DMEM_MMIO_EN
    .leds_o  (leds),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what one rising edge must do to the visible state
  task automatic model_edge(input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
    longint off;
    int w;
    logic [31:0] cur;
`ifdef MIRISCV_DMEM_MMIO_EN
    logic [31:0] cnt_now;
`endif
    if (!arstn) begin
      exp_rdata = 32'h0;
      exp_err   = 1'b0;
`ifdef MIRISCV_DMEM_MMIO_EN
      exp_leds  = 16'h0;
      cnt_m     = 32'h0;
`endif
      return;
    end
`ifdef MIRISCV_DMEM_MMIO_EN
    cnt_now = cnt_m;
    cnt_m   = cnt_m + 32'd1;
`endif
    exp_err = 1'b0;
    if (!req) return;
`ifdef MIRISCV_DMEM_MMIO_EN
    if ((addr & ~32'd3) == MMIO) begin
      if (we) begin
        if (be[0]) exp_leds[7:0]  = wdata[7:0];
        if (be[1]) exp_leds[15:8] = wdata[15:8];
      end else begin
        exp_rdata = {16'h0, exp_leds};
      end
      return;
    end
    if ((addr & ~32'd3) == MMIO + 32'd4) begin
      if (!we) exp_rdata = cnt_now;
      return;
    end
`endif
    off = longint'(addr) - longint'(BASE);
    if (off >= 0 && off < longint'(4 * DEPTH)) begin
      w = int'(off / 4);
      cur = mem_m.exists(w) ? mem_m[w] : 32'hx;
      if (we) begin
        for (int n = 0; n < 4; n++) if (be[n]) cur[8*n +: 8] = wdata[8*n +: 8];
        mem_m[w] = cur;
      end else begin
        exp_rdata = cur;
      end
    end else begin
      exp_err = 1'b1;
      if (!we) exp_rdata = 32'h0;
    end
  endtask

  // One bus cycle: drive at the falling edge, advance the model at the rising edge
  task automatic op(input logic req, input logic we, input logic [3:0] be,
                    input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    if (rel_pending) begin
      arstn = 1'b1;
      rel_pending = 1'b0;
    end
    bus.data_req_i   = req;
    bus.data_we_i    = we;
    bus.data_be_i    = be;
    bus.data_addr_i  = addr;
    bus.data_wdata_i = wdata;
    @(posedge clk);
    model_edge(req, we, be, addr, wdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'bx, 4'hx, 32'hx, 32'hx);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be);
    op(1'b1, 1'b1, be, addr, d);
  endtask

  task automatic rd(input logic [31:0] addr);
    op(1'b1, 1'b0, 4'hx, addr, 32'hx);
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!$isunknown(exp_rdata)) check("rdata", bus.data_rdata_o, exp_rdata);
      check("err", 32'(bus.data_err_o), 32'(exp_err));
`ifdef MIRISCV_DMEM_MMIO_EN
      check("leds", 32'(leds), 32'(exp_leds));
`endif
    end
  end

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'h0;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;

    // Reset held 3 cycles, then 5 idle cycles
    idle(3);
    rel_pending = 1'b1;
    idle(1);
    #1 check("rst_rdata", bus.data_rdata_o, 32'h0);
    check("rst_err", 32'(bus.data_err_o), 32'h0);
    idle(4);
    #1 check("idle_rdata", bus.data_rdata_o, 32'h0);

    // Full word write then read back
    wr(BASE + 8, 32'hDEADBEEF, 4'hF);
    rd(BASE + 8);
    #1 check("rd_full", bus.data_rdata_o, 32'hDEADBEEF);

    // Byte-lane merge, then a be=0 no-op write
    wr(BASE + 10, 32'h5A5A5A5A, 4'b0100);
    rd(BASE + 8);
    #1 check("rd_merge", bus.data_rdata_o, 32'hDE5ABEEF);
    wr(BASE + 8, 32'h12345678, 4'b0000);
    rd(BASE + 8);
    #1 check("rd_be0", bus.data_rdata_o, 32'hDE5ABEEF);

    // Last word in range
    wr(LAST, 32'hCAFEF00D, 4'hF);
    rd(LAST);
    #1 check("rd_last", bus.data_rdata_o, 32'hCAFEF00D);
    check("err_last", 32'(bus.data_err_o), 32'h0);

    // Bounds: one past the end, below base, top of address space
    rd(BASE + 4 * DEPTH);
    #1 check("oob_rdata", bus.data_rdata_o, 32'h0);
    check("oob_err", 32'(bus.data_err_o), 32'h1);
    idle(1);
    #1 check("err_clear", 32'(bus.data_err_o), 32'h0);
    wr(BASE - 4, 32'h1, 4'hF);
    #1 check("below_err", 32'(bus.data_err_o), 32'h1);
    wr(32'hFFFF_FFFC, 32'h2, 4'hF);
    rd(LAST);
    #1 check("last_kept", bus.data_rdata_o, 32'hCAFEF00D);

    // Back-to-back writes and reads
    wr(BASE + 12, 32'h0000_0003, 4'hF);
    wr(BASE + 16, 32'h0000_0004, 4'hF);
    rd(BASE + 12);
    rd(BASE + 16);
    #1 check("b2b_rd", bus.data_rdata_o, 32'h0000_0004);
    rd(BASE + 12);
    idle(1);

    // Async reset mid-read; write during reset must not land
    wr(BASE + 20, 32'h1111_2222, 4'hF);
    rd(BASE + 20);
    rd(BASE + 8);
    #2 arstn = 1'b0;
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
`ifdef MIRISCV_DMEM_MMIO_EN
    exp_leds  = 16'h0;
    cnt_m     = 32'h0;
`endif
    #1 check("async_rst", bus.data_rdata_o, 32'h0);
    wr(BASE + 20, 32'h3333_4444, 4'hF);
    rel_pending = 1'b1;
    idle(1);
    rd(BASE + 20);
    #1 check("rst_nowrite", bus.data_rdata_o, 32'h1111_2222);

`ifdef MIRISCV_DMEM_MMIO_EN
    // MMIO: LED register, counter reads 10 edges apart, no error pulses
    wr(MMIO, 32'h0000_ABCD, 4'b0011);
    #1 check("leds_lit", 32'(leds), 32'h0000_ABCD);
    check("mmio_err", 32'(bus.data_err_o), 32'h0);
    rd(MMIO);
    #1 check("leds_rd", bus.data_rdata_o, 32'h0000_ABCD);
    rd(MMIO + 4);
    #1 v1 = bus.data_rdata_o;
    idle(9);
    rd(MMIO + 4);
    #1 v2 = bus.data_rdata_o;
    check("cnt_delta", v2 - v1, 32'd10);
    wr(MMIO + 4, 32'hFFFF_FFFF, 4'hF);
    #1 check("cnt_wr_err", 32'(bus.data_err_o), 32'h0);
`else
    // Without MMIO the window is a miss
    wr(MMIO, 32'h0000_ABCD, 4'b0011);
    #1 check("mmio_off_err", 32'(bus.data_err_o), 32'h1);
    rd(MMIO + 4);
    #1 check("mmio_off_rd", bus.data_rdata_o, 32'h0);
`endif
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/miriscv_data_mem.md
Name: miriscv_data_mem

Overview:
- Single-port data memory that responds to the core's load/store unit memory protocol.
- It is the responder end of the interface the LSU drives.
- Accepts one request per cycle, writes byte lanes selected by data_be_i, and returns a full aligned word one cycle after a read request.
- The LSU performs lane extraction and sign/zero extension; this block never does.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >= 4).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- MMIO_ADDR, 32'h8000_0000, byte address of the MMIO register window (used only with the optional feature).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- arstn_i  input  1  asynchronous reset, active low.
- data_req_i  input  1  request valid this cycle.
- data_we_i  input  1  1 = write, 0 = read; qualified by data_req_i.
- data_be_i  input  4  byte-lane enables for writes; bit n selects bits [8n+7:8n].
- data_addr_i  input  32  byte address; bits [1:0] are ignored for indexing.
- data_wdata_i  input  32  write data, already lane-replicated by the initiator.
- data_rdata_o  output  32  registered read data.
- data_err_o  output  1  registered one-cycle pulse: the previous request was out of range.
- leds_o  output  16  present only with MIRISCV_DMEM_MMIO_EN; LED register.

Behaviour:
- Reset: clk_i single clock; arstn_i asynchronous, active low. While arstn_i=0: data_rdata_o=0, data_err_o=0, leds_o=0, cycle counter=0. The memory array is not reset. No write takes effect while arstn_i=0, including a request coincident with the assertion edge.
- Decode:
  - idx = (data_addr_i - BASE_ADDR) >> 2, computed at 32 bits.
  - in_range = (data_addr_i >= BASE_ADDR) && (data_addr_i < BASE_ADDR + 4*DEPTH_WORDS).
  - The upper-bound comparison must not wrap: a 33-bit compare is used.
- Write (data_req_i && data_we_i && in_range) at the rising edge: for each n with data_be_i[n]=1, mem[idx][8n+7:8n] <= data_wdata_i[8n+7:8n]. Lanes with be=0 are unchanged. be=4'b0000 is a legal no-op. data_rdata_o holds its previous value.
- Read (data_req_i && !data_we_i && in_range):
  - data_rdata_o <= mem[idx] at the edge, so it is valid in the cycle after the request (latency 1).
  - This matches the LSU's one-cycle stall.
  - data_be_i is ignored for reads.
- Idle (data_req_i=0): data_rdata_o holds; no array change; data_err_o <= 0.
- Out of range:
  - A request (read or write) with !in_range, and not hitting MMIO when enabled, sets data_err_o <= 1 for exactly one cycle.
  - An out-of-range write has no effect.
  - An out-of-range read sets data_rdata_o <= 32'h0.
- Back-to-back:
  - A write to word A at edge k followed by a read of A at edge k+1 returns the new data at cycle k+2. No bypass is needed because the port is single.
  - Consecutive reads each update data_rdata_o every cycle.
- data_err_o is cleared on the next edge of any non-erroring cycle.
- X-safety: with data_req_i=0, other inputs may be X without affecting state.

Optional Feature:
MIRISCV_DMEM_MMIO_EN.
- Defined:
  - Adds port leds_o, a 16-bit LED register.
  - Adds a 32-bit free-running cycle counter, incremented every clock after reset and wrapping 32'hFFFF_FFFF -> 0.
- Word-aligned MMIO_ADDR:
  - Writes update leds_o[7:0] if be[0] and leds_o[15:8] if be[1]; be[3:2] are ignored.
  - Reads return {16'h0, leds_o}, latency 1.
- MMIO_ADDR+4 is read-only:
  - Reads return the counter value sampled at the request edge.
  - Writes are ignored without error.
- MMIO hits never assert data_err_o.
- Not defined: no leds_o port, no counter; MMIO addresses are treated as out of range.

Test Plan:
- Reset then idle: arstn_i low 3 cycles, release -> data_rdata_o=0, data_err_o=0; no change for 5 idle cycles.
- Full-word write/read: write 32'hDEADBEEF, be=4'hF, addr BASE+8; read addr BASE+8 next cycle -> data_rdata_o=32'hDEADBEEF one cycle after the read request.
- Byte-lane merge: after the above, write data 32'h5A5A5A5A, be=4'b0100, addr BASE+10; read BASE+8 -> 32'hDE5ABEEF. A be=4'b0000 write then leaves it 32'hDE5ABEEF.
- Bounds: read BASE+4*DEPTH_WORDS -> data_rdata_o=0, data_err_o=1 for one cycle. Write 32'h1 to BASE-4 (with BASE_ADDR>0 configuration) -> err pulse, array unchanged. Last word BASE+4*DEPTH_WORDS-4 reads/writes without error.
- Async reset mid-operation: assert arstn_i between edges during a read sequence -> data_rdata_o drops to 0 immediately. A write requested in the reset cycle does not modify memory (readback after release shows the old value).
- MMIO (macro defined): write 32'h0000ABCD, be=4'b0011 to MMIO_ADDR -> leds_o=16'hABCD. Read MMIO_ADDR+4 at two requests 10 cycles apart -> values differ by 10. No data_err_o.
